// File: rtl/microcode_sequencer_if.sv
// Handshake/bus bundle between the microcode sequencer and the CountNoX datapath.
// master: sequencer side (drives cond_sel, upc, strobes, status; reads cond).
// slave : datapath/mux side (drives cond; reads everything else).
interface microcode_sequencer_if #(
  parameter int STATE_W = 3
);
  logic               cond;      // selected condition from the external 4:1 mux
  logic [1:0]         cond_sel;  // 00 go, 01 operand==0, 10 operand LSB, 11 one
  logic [STATE_W-1:0] upc;       // current microprogram counter
  logic               ld_a;      // load operand register
  logic               sh_a;      // shift operand register right by one
  logic               clr_cnt;   // clear ones counter
  logic               inc_cnt;   // increment ones counter
  logic               ready;     // idle, accepting go
  logic               done_o;    // result valid

  modport master (
    input  cond,
    output cond_sel, upc, ld_a, sh_a, clr_cnt, inc_cnt, ready, done_o
  );

  modport slave (
    output cond,
    input  cond_sel, upc, ld_a, sh_a, clr_cnt, inc_cnt, ready, done_o
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Two-address microcode sequencer for the CountNoX ones-counting datapath.
// Ports: clk, reset (sync, active-high), bus (master modport: cond in;
// cond_sel, upc, ld_a, sh_a, clr_cnt, inc_cnt, ready, done_o out).
// Moore machine: all outputs decode from upc; next address = cond ? NST : NSF.
module microcode_sequencer #(
  parameter int                 STATE_W     = 3,
  parameter logic [STATE_W-1:0] RESET_STATE = 3'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  microcode_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_BIT   = 3'd3,
    S_INC   = 3'd4,
    S_DONE  = 3'd5,
    S_SHIFT = 3'd6,
    S_SPARE = 3'd7
  } state_e;

  localparam logic [1:0] SEL_GO   = 2'b00;
  localparam logic [1:0] SEL_ZERO = 2'b01;
  localparam logic [1:0] SEL_LSB  = 2'b10;
  localparam logic [1:0] SEL_ONE  = 2'b11;

  logic [STATE_W-1:0] upc_q;
  logic [STATE_W-1:0] upc_d;
  logic [STATE_W-1:0] nst;
  logic [STATE_W-1:0] nsf;
  logic [1:0]         sel;
  logic               ld_a, sh_a, clr_cnt, inc_cnt, ready, done_o;

  // Control store. Words using SEL_ONE carry NST == NSF so a faulty mux
  // cannot misroute them.
  always_comb begin
    sel     = SEL_ONE;
    nst     = S_IDLE;
    nsf     = S_IDLE;
    ld_a    = 1'b0;
    sh_a    = 1'b0;
    clr_cnt = 1'b0;
    inc_cnt = 1'b0;
    ready   = 1'b0;
    done_o  = 1'b0;
    case (upc_q)
      S_IDLE:  begin sel = SEL_GO;   nst = S_LOAD; nsf = S_IDLE;  ready = 1'b1; end
      S_LOAD:  begin sel = SEL_ONE;  nst = S_TEST; nsf = S_TEST;  ld_a = 1'b1; clr_cnt = 1'b1; end
      S_TEST:  begin sel = SEL_ZERO; nst = S_DONE; nsf = S_BIT;   end
      S_BIT:   begin sel = SEL_LSB;  nst = S_INC;  nsf = S_SHIFT; end
      S_INC:   begin sel = SEL_ONE;  nst = S_TEST; nsf = S_TEST;  inc_cnt = 1'b1; sh_a = 1'b1; end
      // Holds while go stays high so a new run needs go to be seen low first.
      S_DONE:  begin sel = SEL_GO;   nst = S_DONE; nsf = S_IDLE;  done_o = 1'b1; end
      S_SHIFT: begin sel = SEL_ONE;  nst = S_TEST; nsf = S_TEST;  sh_a = 1'b1; end
      // Unreachable recovery word.
      S_SPARE: begin sel = SEL_ONE;  nst = S_IDLE; nsf = S_IDLE;  end
      default: begin sel = SEL_ONE;  nst = S_IDLE; nsf = S_IDLE;  end
    endcase
    upc_d = bus.cond ? nst : nsf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upc_q <= RESET_STATE;
    end else begin
      upc_q <= upc_d;
    end
  end

  assign bus.upc      = upc_q;
  assign bus.cond_sel = sel;
  assign bus.ld_a     = ld_a;
  assign bus.sh_a     = sh_a;
  assign bus.clr_cnt  = clr_cnt;
  assign bus.inc_cnt  = inc_cnt;
  assign bus.ready    = ready;
  assign bus.done_o   = done_o;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer with a cycle-level model of the
// external condition mux and the operand/counter datapath.
module tb_microcode_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  microcode_sequencer_if bus ();

  microcode_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic       go;
  logic [7:0] operand;
  logic [7:0] a_q;
  int         cnt;
  int         n_ld, n_sh, n_inc, n_clr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // External 4:1 condition mux.
  task automatic drive_cond();
    case (bus.cond_sel)
      2'b00:   bus.cond = go;
      2'b01:   bus.cond = (a_q == 8'd0);
      2'b10:   bus.cond = a_q[0];
      default: bus.cond = 1'b1;
    endcase
  endtask

  // One clock: strobes seen in the current cycle act on the datapath at the edge.
  task automatic tick();
    logic ld, sh, inc, clr;
    ld  = bus.ld_a;
    sh  = bus.sh_a;
    inc = bus.inc_cnt;
    clr = bus.clr_cnt;
    @(posedge clk);
    if (ld === 1'b1)  a_q = operand;
    if (clr === 1'b1) cnt = 0;
    if (sh === 1'b1)  a_q = a_q >> 1;
    if (inc === 1'b1) cnt++;
    n_ld  += (ld === 1'b1)  ? 1 : 0;
    n_sh  += (sh === 1'b1)  ? 1 : 0;
    n_inc += (inc === 1'b1) ? 1 : 0;
    n_clr += (clr === 1'b1) ? 1 : 0;
    #1;
    drive_cond();
  endtask

  task automatic clr_counts();
    n_ld = 0; n_sh = 0; n_inc = 0; n_clr = 0;
  endtask

  initial begin
    int t;
    int seq_exp [3];
    int inc_snap, sh_snap;
    seq_exp = '{1, 2, 5};

    reset = 1'b1; go = 1'b0; operand = 8'd0; a_q = 8'd0; cnt = 0;
    clr_counts();
    bus.cond = 1'($urandom_range(0, 1));

    // Reset with random cond
    repeat (2) begin
      tick();
      bus.cond = 1'($urandom_range(0, 1));
    end
    check("rst_upc",      32'(bus.upc), 0);
    check("rst_ready",    32'(bus.ready), 1);
    check("rst_cond_sel", 32'(bus.cond_sel), 0);
    check("rst_strobes",  32'({bus.ld_a, bus.sh_a, bus.clr_cnt, bus.inc_cnt}), 0);
    check("rst_done",     32'(bus.done_o), 0);
    reset = 1'b0;
    drive_cond();
    clr_counts();

    // Idle hold with go low
    repeat (10) tick();
    check("idle_upc",     32'(bus.upc), 0);
    check("idle_pulses",  32'(n_ld + n_sh + n_inc + n_clr), 0);
    check("idle_ready",   32'(bus.ready), 1);

    // Zero operand: 0 -> 1 -> 2 -> 5
    operand = 8'd0; go = 1'b1;
    drive_cond();
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("zero_seq%0d", i), 32'(bus.upc), 32'(seq_exp[i]));
    end
    check("zero_done",    32'(bus.done_o), 1);
    check("zero_ld",      32'(n_ld), 1);
    check("zero_clr",     32'(n_clr), 1);
    check("zero_inc",     32'(n_inc), 0);
    check("zero_cnt",     32'(cnt), 0);

    // go held high keeps DONE
    repeat (3) tick();
    check("hold_upc",     32'(bus.upc), 5);
    check("hold_done",    32'(bus.done_o), 1);
    go = 1'b0;
    drive_cond();
    tick();
    check("drop_upc",     32'(bus.upc), 0);
    check("drop_ready",   32'(bus.ready), 1);
    check("drop_done",    32'(bus.done_o), 0);
    repeat (3) tick();
    check("norelaunch",   32'(bus.upc), 0);

    // Operand 1011: 4 iterations, 3 ones
    clr_counts();
    operand = 8'b0000_1011; go = 1'b1;
    drive_cond();
    t = 0;
    while (bus.done_o !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    check("op1011_lat",   32'(t), 15);
    check("op1011_inc",   32'(n_inc), 3);
    check("op1011_sh",    32'(n_sh), 4);
    check("op1011_ld",    32'(n_ld), 1);
    check("op1011_cnt",   32'(cnt), 3);
    tick();
    check("op1011_hold",  32'(bus.upc), 5);
    go = 1'b0;
    drive_cond();
    tick();
    check("op1011_idle",  32'(bus.upc), 0);
    check("op1011_rdy",   32'(bus.ready), 1);

    // Relaunch once go rises again
    go = 1'b1;
    drive_cond();
    tick();
    check("relaunch_upc", 32'(bus.upc), 1);
    check("relaunch_ld",  32'(bus.ld_a), 1);

    // Reset while in INC
    t = 0;
    while (bus.upc !== 3'd4 && t < 50) begin
      tick();
      t++;
    end
    check("reach_inc",    32'(bus.upc), 4);
    reset = 1'b1;
    tick();
    check("midrst_upc",   32'(bus.upc), 0);
    inc_snap = n_inc;
    sh_snap  = n_sh;
    reset = 1'b0; go = 1'b0;
    drive_cond();
    repeat (5) tick();
    check("midrst_inc",   32'(n_inc), 32'(inc_snap));
    check("midrst_sh",    32'(n_sh), 32'(sh_snap));
    check("midrst_idle",  32'(bus.upc), 0);

    // Backdoor into SPARE recovers to IDLE
    force dut.upc_q = 3'd7;
    #1;
    check("spare_upc",    32'(bus.upc), 7);
    check("spare_sel",    32'(bus.cond_sel), 3);
    check("spare_strb",   32'({bus.ld_a, bus.sh_a, bus.clr_cnt, bus.inc_cnt, bus.done_o, bus.ready}), 0);
    release dut.upc_q;
    bus.cond = 1'b0;
    @(posedge clk);
    #1;
    check("spare_recov",  32'(bus.upc), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
